// File: rtl/ai_move_gen_pkg.sv
// Shared types and tables for the tic-tac-toe AI move generator:
// cell/move codes, scan states, line table and positional preference order.
package ai_move_gen_pkg;

    localparam int CELLS  = 9;
    localparam int GRID_W = 18;

    typedef logic [1:0] cell_t;
    typedef logic [3:0] move_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_X     = 2'b01;
    localparam cell_t CELL_O     = 2'b10;

    localparam move_t MOVE_NONE = 4'd0;
    localparam move_t MOVE_A1 = 4'd1, MOVE_A2 = 4'd2, MOVE_A3 = 4'd3;
    localparam move_t MOVE_B1 = 4'd4, MOVE_B2 = 4'd5, MOVE_B3 = 4'd6;
    localparam move_t MOVE_C1 = 4'd7, MOVE_C2 = 4'd8, MOVE_C3 = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WIN,
        ST_BLOCK,
        ST_PREF,
        ST_DONE
    } state_t;

    function automatic logic player_ok(input cell_t p);
        return (p == CELL_X) || (p == CELL_O);
    endfunction

    // Three move codes of a line, packed {first, second, third}.
    function automatic logic [11:0] line_cells(input logic [2:0] line);
        case (line)
            3'd0:    line_cells = {MOVE_A1, MOVE_A2, MOVE_A3};
            3'd1:    line_cells = {MOVE_B1, MOVE_B2, MOVE_B3};
            3'd2:    line_cells = {MOVE_C1, MOVE_C2, MOVE_C3};
            3'd3:    line_cells = {MOVE_A1, MOVE_B1, MOVE_C1};
            3'd4:    line_cells = {MOVE_A2, MOVE_B2, MOVE_C2};
            3'd5:    line_cells = {MOVE_A3, MOVE_B3, MOVE_C3};
            3'd6:    line_cells = {MOVE_A1, MOVE_B2, MOVE_C3};
            default: line_cells = {MOVE_A3, MOVE_B2, MOVE_C1};
        endcase
    endfunction

    // Centre first, then corners, then edges.
    function automatic move_t pref_cell(input logic [3:0] p);
        case (p)
            4'd0:    pref_cell = MOVE_B2;
            4'd1:    pref_cell = MOVE_A1;
            4'd2:    pref_cell = MOVE_A3;
            4'd3:    pref_cell = MOVE_C1;
            4'd4:    pref_cell = MOVE_C3;
            4'd5:    pref_cell = MOVE_A2;
            4'd6:    pref_cell = MOVE_B1;
            4'd7:    pref_cell = MOVE_B3;
            default: pref_cell = MOVE_C2;
        endcase
    endfunction

endpackage

// File: rtl/ai_move_gen_if.sv
// Turn request / move result bundle between the game controller and the AI.
interface ai_move_gen_if;
    import ai_move_gen_pkg::*;

    logic                clear;
    logic                req;
    cell_t               ai_player;
    logic [GRID_W-1:0]   grid;
    logic                busy;
    move_t               move;
    logic                move_valid;
    logic                no_move;

    modport master (
        output clear, req, ai_player, grid,
        input  busy, move, move_valid, no_move
    );

    modport slave (
        input  clear, req, ai_player, grid,
        output busy, move, move_valid, no_move
    );
endinterface

// File: rtl/ai_move_gen_line_eval.sv
// Combinational line check: two cells owned by player and the third empty
// yields a hit and the move code of the empty cell.
module ai_move_gen_line_eval
    import ai_move_gen_pkg::*;
(
    input  cell_t cell_a,
    input  cell_t cell_b,
    input  cell_t cell_c,
    input  move_t code_a,
    input  move_t code_b,
    input  move_t code_c,
    input  cell_t player,
    output logic  hit,
    output move_t code
);
    always_comb begin
        hit  = 1'b0;
        code = MOVE_NONE;
        if (cell_a == CELL_EMPTY && cell_b == player && cell_c == player) begin
            hit  = 1'b1;
            code = code_a;
        end else if (cell_b == CELL_EMPTY && cell_a == player && cell_c == player) begin
            hit  = 1'b1;
            code = code_b;
        end else if (cell_c == CELL_EMPTY && cell_a == player && cell_b == player) begin
            hit  = 1'b1;
            code = code_c;
        end
    end
endmodule

// File: rtl/ai_move_gen.sv
// Tic-tac-toe computer opponent: snapshots the board on a turn request and
// scans win lines, then block lines, then preferred cells, one step per cycle.
module ai_move_gen
    import ai_move_gen_pkg::*;
#(
    parameter int EN_BLOCK = 1,
    parameter int CELL_W   = 2
) (
    input logic         clk,
    input logic         rst,
    ai_move_gen_if.slave bus
);
    state_t            state_reg, state_next;
    logic [3:0]        idx_reg, idx_next;
    logic [GRID_W-1:0] snap_reg, snap_next;
    cell_t             player_reg, player_next;
    logic              fail_reg, fail_next;
    move_t             move_reg, move_next;
    logic              move_valid, no_move;

    cell_t       cells [1:CELLS];
    logic [11:0] line_sel;
    move_t       code_a, code_b, code_c;
    cell_t       eval_player;
    logic        line_hit;
    move_t       line_move;
    move_t       pref_code;
    logic        pref_free;

    // Cells indexed by their move code so table entries address them directly.
    generate
        for (genvar gi = 1; gi <= CELLS; gi++) begin : g_cells
            assign cells[gi] = snap_reg[(gi-1)*CELL_W +: CELL_W];
        end
    endgenerate

    assign line_sel    = line_cells(idx_reg[2:0]);
    assign code_a      = line_sel[11:8];
    assign code_b      = line_sel[7:4];
    assign code_c      = line_sel[3:0];
    assign eval_player = (state_reg == ST_BLOCK) ? (player_reg ^ 2'b11) : player_reg;
    assign pref_code   = pref_cell(idx_reg);
    assign pref_free   = (cells[pref_code] == CELL_EMPTY);

    ai_move_gen_line_eval u_line_eval (
        .cell_a (cells[code_a]),
        .cell_b (cells[code_b]),
        .cell_c (cells[code_c]),
        .code_a (code_a),
        .code_b (code_b),
        .code_c (code_c),
        .player (eval_player),
        .hit    (line_hit),
        .code   (line_move)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            snap_reg   <= '0;
            player_reg <= CELL_EMPTY;
            fail_reg   <= 1'b0;
            move_reg   <= MOVE_NONE;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            snap_reg   <= snap_next;
            player_reg <= player_next;
            fail_reg   <= fail_next;
            move_reg   <= move_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        snap_next   = snap_reg;
        player_next = player_reg;
        fail_next   = fail_reg;
        move_next   = move_reg;
        move_valid  = 1'b0;
        no_move     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    snap_next   = bus.grid;
                    player_next = bus.ai_player;
                    fail_next   = !player_ok(bus.ai_player);
                    move_next   = MOVE_NONE;
                    idx_next    = '0;
                    state_next  = ST_WIN;
                end
            end
            ST_WIN: begin
                // An invalid symbol spends one WIN cycle so the fail strobe has fixed latency.
                if (fail_reg) begin
                    state_next = ST_DONE;
                end else if (line_hit) begin
                    move_next  = line_move;
                    state_next = ST_DONE;
                end else if (idx_reg == 4'd7) begin
                    idx_next   = '0;
                    state_next = (EN_BLOCK != 0) ? ST_BLOCK : ST_PREF;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            ST_BLOCK: begin
                if (line_hit) begin
                    move_next  = line_move;
                    state_next = ST_DONE;
                end else if (idx_reg == 4'd7) begin
                    idx_next   = '0;
                    state_next = ST_PREF;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            ST_PREF: begin
                if (pref_free) begin
                    move_next  = pref_code;
                    state_next = ST_DONE;
                end else if (idx_reg == 4'd8) begin
                    fail_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            ST_DONE: begin
                move_valid = !fail_reg;
                no_move    = fail_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Game clear overrides everything, including a pending strobe.
        if (bus.clear) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            move_next  = MOVE_NONE;
            move_valid = 1'b0;
            no_move    = 1'b0;
        end
    end

    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.move       = move_reg;
    assign bus.move_valid = move_valid;
    assign bus.no_move    = no_move;

endmodule

// File: tb/tb_ai_move_gen.sv
// Bench for ai_move_gen: two instances (block on / block off) share stimulus and
// are checked every cycle against a rule-level model of move choice and timing.
module tb_ai_move_gen;
    import ai_move_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ai_move_gen_if bus0 ();
    ai_move_gen_if bus1 ();

    assign bus1.clear     = bus0.clear;
    assign bus1.req       = bus0.req;
    assign bus1.ai_player = bus0.ai_player;
    assign bus1.grid      = bus0.grid;

    ai_move_gen #(.EN_BLOCK(1), .CELL_W(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    ai_move_gen #(.EN_BLOCK(0), .CELL_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    // Reference: cell i (0..8 = A1..C3) lives at grid[2i+1:2i]; move code = i+1.
    int line_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int pref_tab [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

    // Returns chosen code, fail flag and strobe latency n (edges after the req edge).
    function automatic void ref_move(input logic [17:0] g, input logic [1:0] ai, input bit en,
                                     output int code, output bit fail, output int n);
        int who, nme, nemp, hole, base, c;
        code = 0; fail = 1'b0; n = 0;
        if (ai == 2'b00 || ai == 2'b11) begin
            fail = 1'b1; n = 1;
            return;
        end
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1 && !en) continue;
            who = (ph == 0) ? int'(ai) : 3 - int'(ai);
            for (int k = 0; k < 8; k++) begin
                nme = 0; nemp = 0; hole = 0;
                for (int j = 0; j < 3; j++) begin
                    c = int'(g[2*line_tab[k][j] +: 2]);
                    if (c == who) nme++;
                    else if (c == 0) begin nemp++; hole = line_tab[k][j]; end
                end
                if (nme == 2 && nemp == 1) begin
                    code = hole + 1;
                    n = (ph == 0) ? k + 1 : 9 + k;
                    return;
                end
            end
        end
        base = en ? 17 : 9;
        for (int p = 0; p < 9; p++) begin
            if (g[2*pref_tab[p] +: 2] == 2'b00) begin
                code = pref_tab[p] + 1;
                n = base + p;
                return;
            end
        end
        fail = 1'b1;
        n = base + 8;
    endfunction

    function automatic logic [17:0] mk(input string s);
        logic [17:0] g = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "X") g[2*i +: 2] = 2'b01;
            else if (s[i] == "O") g[2*i +: 2] = 2'b10;
        end
        return g;
    endfunction

    // Per-instance model: 0 idle, 1 scanning (cnt edges left), 2 strobe cycle.
    int ph [2]    = '{0, 0};
    int cnt [2]   = '{0, 0};
    int mv [2]    = '{0, 0};
    int pcode [2] = '{0, 0};
    bit pfail [2] = '{0, 0};
    logic o_busy, o_valid, o_nomove;
    logic [3:0] o_move;

    // Inputs only change 1 time unit after a negedge, so the values seen here are
    // the ones the DUTs sampled at the preceding posedge.
    initial forever begin
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                ph[j] = 0; mv[j] = 0;
            end else if (bus0.clear) begin
                ph[j] = 0; mv[j] = 0;
            end else begin
                case (ph[j])
                    0: if (bus0.req) begin
                        ref_move(bus0.grid, bus0.ai_player, j == 0, pcode[j], pfail[j], cnt[j]);
                        mv[j] = 0;
                        ph[j] = 1;
                    end
                    1: begin
                        cnt[j]--;
                        if (cnt[j] == 0) begin
                            ph[j] = 2;
                            if (!pfail[j]) mv[j] = pcode[j];
                        end
                    end
                    default: ph[j] = 0;
                endcase
            end
            o_busy   = (j == 0) ? bus0.busy       : bus1.busy;
            o_move   = (j == 0) ? bus0.move       : bus1.move;
            o_valid  = (j == 0) ? bus0.move_valid : bus1.move_valid;
            o_nomove = (j == 0) ? bus0.no_move    : bus1.no_move;
            chk($sformatf("busy%0d", j), 32'(o_busy), 32'(ph[j] != 0));
            chk($sformatf("move%0d", j), 32'(o_move), mv[j]);
            chk($sformatf("valid%0d", j), 32'(o_valid), 32'(ph[j] == 2 && !pfail[j] && !bus0.clear));
            chk($sformatf("nomove%0d", j), 32'(o_nomove), 32'(ph[j] == 2 && pfail[j] && !bus0.clear));
        end
    end

    task automatic issue(input logic [17:0] g, input logic [1:0] ai);
        repeat (2) @(negedge clk);
        #1;
        bus0.grid = g; bus0.ai_player = ai; bus0.req = 1'b1;
        @(negedge clk);
        #1;
        bus0.req = 1'b0;
    endtask

    task automatic run_case(input string name, input string b, input logic [1:0] ai,
                            input int n0, input int n1, input int m0, input int m1);
        int got0 = -1;
        int got1 = -1;
        issue(mk(b), ai);
        for (int n = 1; n <= 40 && (got0 < 0 || got1 < 0); n++) begin
            @(negedge clk);
            if (got0 < 0 && (bus0.move_valid || bus0.no_move)) got0 = n;
            if (got1 < 0 && (bus1.move_valid || bus1.no_move)) got1 = n;
        end
        chk({name, "_lat0"}, got0, n0);
        chk({name, "_lat1"}, got1, n1);
        chk({name, "_mv0"}, 32'(bus0.move), m0);
        chk({name, "_mv1"}, 32'(bus1.move), m1);
        $display("case %s board=%s ai=%0d lat=%0d/%0d move=%0d/%0d", name, b, ai, got0, got1,
                 bus0.move, bus1.move);
    endtask

    int rc, rn, f0, f1, c0, c1;
    bit rf;
    logic [17:0] rg;
    logic [1:0]  rai;
    bit done;

    initial begin
        rst = 1'b1;
        bus0.clear = 1'b0; bus0.req = 1'b0; bus0.ai_player = 2'b00; bus0.grid = '0;

        // Hand-computed pins for the reference model.
        ref_move(mk("XX......."), 2'b01, 1'b1, rc, rf, rn);
        chk("pin_win_code", rc, 3);   chk("pin_win_n", rn, 1);
        ref_move(mk("X..XO...."), 2'b10, 1'b1, rc, rf, rn);
        chk("pin_blk_code", rc, 7);   chk("pin_blk_n", rn, 12);
        ref_move(mk("........."), 2'b10, 1'b0, rc, rf, rn);
        chk("pin_pref_code", rc, 5);  chk("pin_pref_n", rn, 9);
        ref_move(mk("XOXXOOOXX"), 2'b01, 1'b1, rc, rf, rn);
        chk("pin_full_fail", 32'(rf), 1); chk("pin_full_n", rn, 25);

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_move", 32'(bus0.move), 0);
        chk("rst_valid", 32'(bus0.move_valid), 0);
        chk("rst_nomove", 32'(bus0.no_move), 0);
        #1 rst = 1'b0;

        run_case("win",   "XX.......", 2'b01, 1, 1, 3, 3);
        run_case("block", "X..XO....", 2'b10, 12, 11, 7, 3);
        run_case("pref",  ".........", 2'b10, 17, 9, 5, 5);
        run_case("full",  "XOXXOOOXX", 2'b01, 25, 17, 0, 0);
        run_case("badai", ".........", 2'b11, 1, 1, 0, 0);

        // Snapshot isolation: board turns into a win mid-scan, extra reqs ignored.
        issue(mk("........."), 2'b01);
        c0 = 0; c1 = 0; f0 = -1; f1 = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus0.move_valid || bus0.no_move) begin c0++; if (f0 < 0) f0 = n; end
            if (bus1.move_valid || bus1.no_move) begin c1++; if (f1 < 0) f1 = n; end
            #1;
            if (n == 2) begin bus0.grid = mk("XX......."); bus0.req = 1'b1; end
            if (n == 5) bus0.req = 1'b0;
        end
        chk("snap_lat0", f0, 17); chk("snap_lat1", f1, 9);
        chk("snap_cnt0", c0, 1);  chk("snap_cnt1", c1, 1);
        chk("snap_mv0", 32'(bus0.move), 5);
        $display("case snapshot lat=%0d/%0d strobes=%0d/%0d", f0, f1, c0, c1);

        // Clear sampled at edge 5 aborts both scans.
        issue(mk("........."), 2'b01);
        repeat (4) @(negedge clk);
        #1 bus0.clear = 1'b1;
        @(negedge clk);
        #1 bus0.clear = 1'b0;
        c0 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus0.move_valid || bus0.no_move || bus1.move_valid || bus1.no_move) c0++;
        end
        chk("clr_strobes", c0, 0);
        chk("clr_busy", 32'(bus0.busy), 0);
        chk("clr_move", 32'(bus0.move), 0);
        $display("case clear strobes=%0d", c0);

        // Async reset while instance 0 is in its preference scan.
        issue(mk("........."), 2'b01);
        repeat (16) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("arst_busy0", 32'(bus0.busy), 0);
        chk("arst_move0", 32'(bus0.move), 0);
        chk("arst_valid0", 32'(bus0.move_valid), 0);
        chk("arst_nomove0", 32'(bus0.no_move), 0);
        chk("arst_move1", 32'(bus1.move), 0);
        #1 rst = 1'b0;
        $display("case async_reset busy=%0d move=%0d", bus0.busy, bus0.move);

        for (int t = 0; t < 150; t++) begin
            rg = '0;
            for (int i = 0; i < 9; i++) begin
                rc = int'($urandom_range(0, 9));
                rg[2*i +: 2] = (rc < 4) ? 2'b00 : (rc < 7) ? 2'b01 : 2'b10;
            end
            rai = ($urandom_range(0, 15) == 0) ? 2'(3 * $urandom_range(0, 1)) : 2'($urandom_range(1, 2));
            issue(rg, rai);
            done = 1'b0;
            for (int n = 0; n < 80 && !done; n++) begin
                @(negedge clk);
                #1;
                bus0.req = 1'b0; bus0.clear = 1'b0;
                if (n >= 2 && ph[0] == 0 && ph[1] == 0) begin
                    done = 1'b1;
                end else if (n < 10) begin
                    if ($urandom_range(0, 3) == 0) bus0.grid = 18'($urandom);
                    if ($urandom_range(0, 3) == 0) bus0.req = 1'b1;
                    if ($urandom_range(0, 39) == 0) bus0.clear = 1'b1;
                end
            end
            chk("rand_timeout", 32'(done), 1);
            $display("txn %0d grid=%05h ai=%0d move=%0d/%0d", t, rg, rai, bus0.move, bus1.move);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
